// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for mem_port_arbiter: FSM states and requester ids.
// Imported by the picker and the top; no ports.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection for mem_port_arbiter (combinational).
// In: c_req l_req l_lock last_winner; out: valid winner. Macro MEM_ARB_ROUND_ROBIN_EN.
module mem_arb_picker
  import mem_port_arbiter_pkg::*;
(
  input  logic c_req,
  input  logic l_req,
  input  logic l_lock,
  input  logic last_winner,
  output logic valid,
  output logic winner
);

  logic c_ok;

  assign c_ok  = c_req & ~l_lock;
  assign valid = c_ok | l_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, the side that did not win last time goes first.
  assign winner = (c_ok & l_req) ? ~last_winner
                : (c_ok ? REQ_CORE : REQ_LOADER);
`else
  logic unused_last;
  assign unused_last = last_winner;
  assign winner = c_ok ? REQ_CORE : REQ_LOADER;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory, one access in flight.
// Ports: core c_*, loader l_* (+l_lock), memory m_*, status busy/owner. Macro MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  input  logic          l_lock,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  if (LATENCY < 1) begin : g_lat_chk
    $error("mem_port_arbiter: LATENCY must be >= 1");
  end

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  arb_state_e    state;
  logic [CW-1:0] cnt;
  logic          pick_valid;
  logic          pick_winner;
  logic          last_winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign sel_we    = pick_winner ? l_we    : c_we;
  assign sel_addr  = pick_winner ? l_addr  : c_addr;
  assign sel_wdata = pick_winner ? l_wdata : c_wdata;

  mem_arb_picker u_picker (
    .c_req       (c_req),
    .l_req       (l_req),
    .l_lock      (l_lock),
    .last_winner (last_winner),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to loader so the core takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= REQ_LOADER;
    end else if (state == IDLE && pick_valid) begin
      last_winner <= pick_winner;
    end
  end
`else
  assign last_winner = REQ_LOADER;
`endif

  // m_addr/m_wdata double as the latched command; they hold
  // their value after GRANT until the next win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      c_gnt    <= 1'b0;
      l_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      c_rdata  <= '0;
      l_rdata  <= '0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      busy     <= 1'b0;
      owner    <= REQ_CORE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= GRANT;
            owner   <= pick_winner;
            c_gnt   <= (pick_winner == REQ_CORE);
            l_gnt   <= (pick_winner == REQ_LOADER);
            m_en    <= 1'b1;
            m_we    <= sel_we;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            busy    <= 1'b1;
          end
        end
        GRANT: begin
          state <= WAIT;
          c_gnt <= 1'b0;
          l_gnt <= 1'b0;
          m_en  <= 1'b0;
          m_we  <= 1'b0;
          cnt   <= CNT_LOAD;
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            if (owner == REQ_CORE) begin
              c_rdata  <= m_rdata;
              c_rvalid <= 1'b1;
            end else begin
              l_rdata  <= m_rdata;
              l_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          c_rvalid <= 1'b0;
          l_rvalid <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-scheduled reference model.
// Drives both requesters, l_lock and a behavioural memory; checks every output.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 4;
  localparam int NRUN = 3000;
  localparam int NC   = NRUN + 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, l_req, l_we, l_lock;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata, m_rdata;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          m_en, m_we, busy, owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_lock(l_lock),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy), .owner(owner)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } cmd_t;

  typedef struct {
    int          st;
    int          gap;
    int          start;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          resp;
  } rq_t;

  cmd_t dq0[$];
  cmd_t dq1[$];
  rq_t  rq[2];

  bit          e_cg[NC], e_lg[NC], e_crv[NC], e_lrv[NC];
  bit          e_men[NC], e_we[NC], e_busy[NC], e_own[NC], e_rdchk[NC];
  logic [31:0] e_addr[NC], e_wd[NC], e_rd[NC];

  logic [31:0] mem[64];
  logic [31:0] mmem[64];
  logic [31:0] rdv[NC];
  bit          rdok[NC];

  int cyc, idle_at, last_dec, n_vec, n_bad;
  bit last, did_rst;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h40 + 32'($urandom_range(0, 31)) * 4;
  endfunction

  task automatic check_zero(string tag);
    chk({tag, ".c_gnt"}, 32'(c_gnt), 0);
    chk({tag, ".l_gnt"}, 32'(l_gnt), 0);
    chk({tag, ".c_rvalid"}, 32'(c_rvalid), 0);
    chk({tag, ".l_rvalid"}, 32'(l_rvalid), 0);
    chk({tag, ".m_en"}, 32'(m_en), 0);
    chk({tag, ".m_we"}, 32'(m_we), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".owner"}, 32'(owner), 0);
    chk({tag, ".m_addr"}, m_addr, 0);
    chk({tag, ".m_wdata"}, m_wdata, 0);
    chk({tag, ".c_rdata"}, c_rdata, 0);
    chk({tag, ".l_rdata"}, l_rdata, 0);
  endtask

  task automatic check_cycle();
    chk("c_gnt", 32'(c_gnt), 32'(e_cg[cyc]));
    chk("l_gnt", 32'(l_gnt), 32'(e_lg[cyc]));
    chk("c_rvalid", 32'(c_rvalid), 32'(e_crv[cyc]));
    chk("l_rvalid", 32'(l_rvalid), 32'(e_lrv[cyc]));
    chk("m_en", 32'(m_en), 32'(e_men[cyc]));
    chk("busy", 32'(busy), 32'(e_busy[cyc]));
    if (e_busy[cyc]) chk("owner", 32'(owner), 32'(e_own[cyc]));
    if (e_men[cyc]) begin
      chk("m_we", 32'(m_we), 32'(e_we[cyc]));
      chk("m_addr", m_addr, e_addr[cyc]);
      if (e_we[cyc]) chk("m_wdata", m_wdata, e_wd[cyc]);
    end
    if (e_rdchk[cyc]) begin
      if (e_own[cyc]) chk("l_rdata", l_rdata, e_rd[cyc]);
      else            chk("c_rdata", c_rdata, e_rd[cyc]);
    end
  endtask

  // Memory reacts to what the DUT actually drives; garbage outside
  // the valid slot exposes capture-timing errors.
  task automatic mem_side();
    if (m_en === 1'b1) begin
      rdv[cyc+LAT]  = mem[m_addr[7:2]];
      rdok[cyc+LAT] = 1'b1;
      if (m_we === 1'b1) mem[m_addr[7:2]] = m_wdata;
    end
    m_rdata   = rdok[cyc] ? rdv[cyc] : $urandom();
    rdok[cyc] = 1'b0;
  endtask

  function automatic int next_gap(int i);
    if (i == 0 && dq0.size() > 0) return dq0[0].gap;
    if (i == 1 && dq1.size() > 0) return dq1[0].gap;
    return $urandom_range(0, 3);
  endfunction

  task automatic drive_req(int i);
    cmd_t c;
    if (rq[i].st == 2 && cyc > rq[i].resp) begin
      rq[i].st  = 0;
      rq[i].gap = next_gap(i);
    end
    if (rq[i].st == 0 && cyc >= rq[i].start) begin
      if (rq[i].gap > 0) begin
        rq[i].gap--;
      end else begin
        if (i == 0 && dq0.size() > 0)      c = dq0.pop_front();
        else if (i == 1 && dq1.size() > 0) c = dq1.pop_front();
        else begin
          c.we    = 1'($urandom_range(0, 1));
          c.addr  = rnd_addr();
          c.wdata = $urandom();
          c.gap   = 0;
        end
        rq[i].we    = c.we;
        rq[i].addr  = c.addr;
        rq[i].wdata = c.wdata;
        rq[i].st    = 1;
      end
    end
    if (i == 0) begin
      c_req   = (rq[0].st == 1);
      c_we    = (rq[0].st == 1) ? rq[0].we    : 1'($urandom_range(0, 1));
      c_addr  = (rq[0].st == 1) ? rq[0].addr  : $urandom();
      c_wdata = (rq[0].st == 1) ? rq[0].wdata : $urandom();
    end else begin
      l_req   = (rq[1].st == 1);
      l_we    = (rq[1].st == 1) ? rq[1].we    : 1'($urandom_range(0, 1));
      l_addr  = (rq[1].st == 1) ? rq[1].addr  : $urandom();
      l_wdata = (rq[1].st == 1) ? rq[1].wdata : $urandom();
    end
  endtask

  task automatic drive_lock();
    if (cyc < 15)       l_lock = 1'b1;
    else if (cyc < 200) l_lock = 1'b0;
    else if ($urandom_range(0, 9) == 0) l_lock = ~l_lock;
  endtask

  // Transaction-level model: a win at cycle t books the grant at t+1,
  // busy for LAT+2 cycles, the response at t+2+LAT, next idle at t+3+LAT.
  task automatic decide();
    bit ce, le;
    int w, r;
    logic [5:0] idx;
    if (cyc < idle_at) return;
    ce = c_req && !l_lock;
    le = l_req;
    if (!(ce || le)) return;
    if (ce && le) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = last ? 0 : 1;
`else
      w = 0;
`endif
    end else begin
      w = le ? 1 : 0;
    end
    last = (w == 1);
    e_cg[cyc+1]   = (w == 0);
    e_lg[cyc+1]   = (w == 1);
    e_men[cyc+1]  = 1'b1;
    e_we[cyc+1]   = rq[w].we;
    e_addr[cyc+1] = rq[w].addr;
    e_wd[cyc+1]   = rq[w].wdata;
    for (int k = 1; k <= LAT + 2; k++) begin
      e_busy[cyc+k] = 1'b1;
      e_own[cyc+k]  = (w == 1);
    end
    r = cyc + 2 + LAT;
    if (w == 0) e_crv[r] = 1'b1;
    else        e_lrv[r] = 1'b1;
    idx = rq[w].addr[7:2];
    if (!rq[w].we) begin
      e_rdchk[r] = 1'b1;
      e_rd[r]    = mmem[idx];
    end else begin
      mmem[idx] = rq[w].wdata;
    end
    idle_at    = cyc + 3 + LAT;
    last_dec   = cyc;
    rq[w].st   = 2;
    rq[w].resp = r;
  endtask

  task automatic step();
    check_cycle();
    mem_side();
    drive_req(0);
    drive_req(1);
    drive_lock();
    decide();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_zero("mid_rst");
    for (int i = cyc; i < NC; i++) begin
      e_cg[i] = 0; e_lg[i] = 0; e_crv[i] = 0; e_lrv[i] = 0;
      e_men[i] = 0; e_busy[i] = 0; e_rdchk[i] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      rq[i].st  = 0;
      rq[i].gap = $urandom_range(0, 3);
    end
    c_req = 1'b0;
    l_req = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_zero("in_rst");
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset   = 1'b1;
    idle_at = cyc;
    last    = 1'b1;
    did_rst = 1'b1;
  endtask

  initial begin
    cmd_t c;
    reset = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    l_lock = 1'b1;
    m_rdata = 0;
    n_vec = 0; n_bad = 0; did_rst = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]  = $urandom();
      mmem[i] = mem[i];
    end
    mem[16]  = 32'hDEADBEEF;
    mmem[16] = 32'hDEADBEEF;
    for (int i = 0; i < NC; i++) begin
      e_cg[i] = 0; e_lg[i] = 0; e_crv[i] = 0; e_lrv[i] = 0;
      e_men[i] = 0; e_we[i] = 0; e_busy[i] = 0; e_own[i] = 0;
      e_rdchk[i] = 0; e_addr[i] = 0; e_wd[i] = 0; e_rd[i] = 0;
      rdok[i] = 0; rdv[i] = 0;
    end
    c = '{we: 1'b0, addr: 32'h40, wdata: 32'h0, gap: 0};
    dq0.push_back(c);
    c = '{we: 1'b0, addr: 32'h80, wdata: 32'h0, gap: 10};
    dq0.push_back(c);
    c = '{we: 1'b1, addr: 32'h80, wdata: 32'h12345678, gap: 0};
    dq1.push_back(c);
    rq[0] = '{st: 0, gap: 0, start: 0, we: 0, addr: 0, wdata: 0, resp: 0};
    rq[1] = '{st: 0, gap: 0, start: 20, we: 0, addr: 0, wdata: 0, resp: 0};

    repeat (3) @(negedge clk);
    check_zero("rst");
    reset    = 1'b1;
    cyc      = 0;
    idle_at  = 0;
    last_dec = -100;
    last     = 1'b1;

    for (int n = 0; n < NRUN; n++) begin
      if (!did_rst && cyc >= 1500 &&
          cyc >= last_dec + 2 && cyc <= last_dec + 1 + LAT)
        do_reset();
      step();
    end
    chk("rst_hit", 32'(did_rst), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
